// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, op encodings and helpers for the frame-buffer memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int WBEN_W  = 4;
    localparam int MAX_REQ = 8;
    localparam int ID_W    = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Bit n of the one-hot code for requester id.
    function automatic logic onehot(input logic [ID_W-1:0] id, input int n);
        return (int'(id) == n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin winner selection with optional fixed priority for requester 0.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] rts,
    input  logic [ID_W-1:0]    ptr,
    input  logic               prio0_en,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    localparam int SUM_W = ID_W + 1;

    logic [MAX_REQ-1:0] rts_pad;
    logic [ID_W-1:0]    cand [NUM_REQ];

    assign rts_pad = MAX_REQ'(rts);
    assign any_req = |rts;

    // cand[k] is the requester index k places after the pointer, wrapped.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum      = {1'b0, ptr} + SUM_W'(gi);
        assign cand[gi] = (sum >= SUM_W'(NUM_REQ)) ? ID_W'(sum - SUM_W'(NUM_REQ))
                                                    : sum[ID_W-1:0];
    end

    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rts_pad[cand[k]]) winner = cand[k];
        end
        if (prio0_en && rts[0]) winner = '0;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port frame-buffer memory between display refresh and drawing engines,
// registering one command per cycle and routing read data back to the issuing requester.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int RD_LAT  = 2,
    parameter int PRIO0   = 1
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic [NUM_REQ-1:0]        req_rts,
    output logic [NUM_REQ-1:0]        req_rtr,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*WBEN_W-1:0] req_wben,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        rsp_xfc,
    input  logic                      mem_rdy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [WBEN_W-1:0]         mem_wben,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int              TAG_W   = ID_W * RD_LAT;
    localparam logic [ID_W-1:0] PTR_RST = ID_W'((NUM_REQ > 1) ? 1 : 0);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic               transfer;
    logic               win_op;
    logic               cmd_rd_reg;
    logic [ID_W-1:0]    cmd_id_reg;
    logic [RD_LAT-1:0]  tag_vld_reg;
    logic [TAG_W-1:0]   tag_id_reg;
    logic               tail_vld;
    logic [ID_W-1:0]    tail_id;
    logic [NUM_REQ-1:0] xfc_next;
    logic [MAX_REQ-1:0] op_pad;
    logic [ADDR_W-1:0]  addr_arr [MAX_REQ];
    logic [DATA_W-1:0]  data_arr [MAX_REQ];
    logic [WBEN_W-1:0]  wben_arr [MAX_REQ];

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .rts      (req_rts),
        .ptr      (ptr_reg),
        .prio0_en (PRIO0 != 0),
        .winner   (winner),
        .any_req  (any_req)
    );

    // Winner always has rts set, so a grant is a transfer; no grants while in reset.
    assign transfer = any_req & mem_rdy & ~rst_;
    assign win_op   = op_pad[winner];
    assign tail_vld = tag_vld_reg[RD_LAT-1];
    assign tail_id  = tag_id_reg[TAG_W-1 -: ID_W];

    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_req
        if (gi < NUM_REQ) begin : g_used
            assign op_pad[gi]   = req_op[gi];
            assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
            assign data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
            assign wben_arr[gi] = req_wben[WBEN_W*gi +: WBEN_W];
            assign req_rtr[gi]  = transfer & onehot(winner, gi);
            assign xfc_next[gi] = tail_vld & onehot(tail_id, gi);
        end else begin : g_pad
            assign op_pad[gi]   = 1'b0;
            assign addr_arr[gi] = '0;
            assign data_arr[gi] = '0;
            assign wben_arr[gi] = '0;
        end
    end

    // A priority win by the display reader leaves the rotation untouched.
    always_comb begin
        ptr_next = ptr_reg;
        if (transfer && !((PRIO0 != 0) && (winner == '0))) begin
            ptr_next = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            ptr_reg    <= PTR_RST;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wben   <= '0;
            cmd_rd_reg <= 1'b0;
            cmd_id_reg <= '0;
        end else begin
            ptr_reg    <= ptr_next;
            mem_en     <= transfer;
            cmd_rd_reg <= transfer && (win_op == OP_READ);
            cmd_id_reg <= winner;
            if (transfer) begin
                mem_we    <= win_op;
                mem_addr  <= addr_arr[winner];
                mem_wdata <= data_arr[winner];
                mem_wben  <= (win_op == OP_WRITE) ? wben_arr[winner] : '0;
            end
        end
    end

    // Tags trail the issued command so the tail lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst_) begin
            tag_vld_reg <= '0;
            tag_id_reg  <= '0;
            rsp_xfc     <= '0;
            rsp_data    <= '0;
        end else begin
            tag_vld_reg <= RD_LAT'({tag_vld_reg, cmd_rd_reg});
            tag_id_reg  <= TAG_W'({tag_id_reg, cmd_id_reg});
            rsp_xfc     <= xfc_next;
            if (tail_vld) rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a PRIO0=1 instance with a memory model,
// plus a PRIO0=0 instance sharing the same stimulus for round-robin ordering.
module tb_mem_bus_arbiter;

    localparam int N  = 3;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_;
    logic [N-1:0]  req_rts;
    logic [N-1:0]  req_op;
    logic [N*16-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N*4-1:0]  req_wben;
    logic          mem_rdy;

    logic [N-1:0]  rtr, xfc;
    logic [31:0]   rsp_data;
    logic          mem_en, mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_wben;

    logic [N-1:0]  rr_rtr, rr_xfc;
    logic [31:0]   rr_rsp_data;
    logic          rr_mem_en, rr_mem_we;
    logic [15:0]   rr_mem_addr;
    logic [31:0]   rr_mem_wdata;
    logic [31:0]   rr_mem_rdata;
    logic [3:0]    rr_mem_wben;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_rr [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    always #5 clk = ~clk;

    assign rr_mem_rdata = 32'h0;

    mem_bus_arbiter #(.NUM_REQ(N), .RD_LAT(RL), .PRIO0(1)) dut (
        .clk(clk), .rst_(rst_), .req_rts(req_rts), .req_rtr(rtr), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_wben(req_wben),
        .rsp_data(rsp_data), .rsp_xfc(xfc), .mem_rdy(mem_rdy), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wben(mem_wben), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.NUM_REQ(N), .RD_LAT(RL), .PRIO0(0)) dut_rr (
        .clk(clk), .rst_(rst_), .req_rts(req_rts), .req_rtr(rr_rtr), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_wben(req_wben),
        .rsp_data(rr_rsp_data), .rsp_xfc(rr_xfc), .mem_rdy(mem_rdy), .mem_en(rr_mem_en),
        .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_wben(rr_mem_wben), .mem_rdata(rr_mem_rdata)
    );

    // Memory model: executes every issued command, read data valid RL cycles after mem_en.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RL];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= merge(mem[mem_addr[7:0]], mem_wdata, mem_wben);
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'h0;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign mem_rdata = rd_pipe[RL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_     = 1'b1;
        req_rts  = 3'b111;
        req_op   = '0;
        req_addr = '0;
        req_data = '0;
        req_wben = '0;
        mem_rdy  = 1'b1;

        // Reset held three cycles with every requester asking.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_rtr", rtr, 3'b000);
            chk("rst_rr_rtr", rr_rtr, 3'b000);
            chk("rst_mem_en", mem_en, 1'b0);
            chk("rst_xfc", xfc, 3'b000);
        end
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        rst_    = 1'b0;
        req_rts = '0;

        // Requester 1 writes 0xDEADBEEF to 0x0040.
        req_rts = 3'b010;  req_op[1] = 1'b1;
        req_addr[31:16] = 16'h0040;  req_data[63:32] = 32'hDEADBEEF;  req_wben[7:4] = 4'hF;
        #1 chk("wr_rtr", rtr, 3'b010);
        cyc();
        req_rts = '0;
        chk("wr_mem_en", mem_en, 1'b1);
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_addr", mem_addr, 16'h0040);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_mem_wben", mem_wben, 4'hF);
        chk("wr_no_xfc", xfc, 3'b000);
        cyc();
        chk("wr_idle_en", mem_en, 1'b0);

        // Requester 2 reads 0x0040; response 4 cycles after accept.
        req_rts = 3'b100;  req_op[2] = 1'b0;  req_addr[47:32] = 16'h0040;
        #1 chk("rd_rtr", rtr, 3'b100);
        cyc();
        req_rts = '0;
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_we", mem_we, 1'b0);
        chk("rd_mem_wben", mem_wben, 4'h0);
        cyc();
        cyc();
        chk("rd_xfc_early", xfc, 3'b000);
        cyc();
        chk("rd_xfc", xfc, 3'b100);
        chk("rd_data", rsp_data, 32'hDEADBEEF);
        cyc();
        chk("rd_xfc_end", xfc, 3'b000);

        // Fresh pointer, all requesters writing: rotation vs fixed priority.
        rst_ = 1'b1;
        cyc();
        rst_     = 1'b0;
        req_rts  = 3'b111;
        req_op   = 3'b111;
        req_addr = {16'h0102, 16'h0101, 16'h0100};
        req_data = {32'h33332222, 32'h22221111, 32'h11110000};
        req_wben = 12'hFFF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_order", rr_rtr, exp_rr[i]);
            chk("prio0_hold", rtr, 3'b001);
            cyc();
        end
        req_rts = 3'b110;
        #1;
        chk("prio0_resume1", rtr, 3'b010);
        chk("rr_resume1", rr_rtr, 3'b010);
        cyc();
        chk("prio0_resume2", rtr, 3'b100);
        chk("rr_resume2", rr_rtr, 3'b100);
        cyc();
        req_rts = '0;

        // Two reads in flight across a 3-cycle memory stall.
        req_rts = 3'b010;  req_op = 3'b000;  req_addr[31:16] = 16'h0040;
        #1 chk("st_rtr1", rtr, 3'b010);
        cyc();
        req_rts = 3'b100;  req_addr[47:32] = 16'h0101;
        #1 chk("st_rtr2", rtr, 3'b100);
        cyc();
        req_rts = 3'b111;  mem_rdy = 1'b0;
        #1 chk("stall_rtr", rtr, 3'b000);
        chk("stall_xfc0", xfc, 3'b000);
        cyc();
        chk("stall_rtr", rtr, 3'b000);
        chk("stall_xfc0", xfc, 3'b000);
        cyc();
        chk("stall_rtr", rtr, 3'b000);
        chk("stall_rr_rtr", rr_rtr, 3'b000);
        chk("stall_xfc1", xfc, 3'b010);
        chk("stall_data1", rsp_data, 32'hDEADBEEF);
        cyc();
        mem_rdy = 1'b1;  req_op = 3'b111;
        chk("stall_xfc2", xfc, 3'b100);
        chk("stall_data2", rsp_data, 32'h22221111);
        #1 chk("ptr_frozen", rr_rtr, 3'b001);
        cyc();
        req_rts = '0;
        chk("stall_xfc_end", xfc, 3'b000);
        cyc();

        // Read then partial write to the same address: read sees old data.
        req_rts = 3'b100;  req_op = 3'b000;  req_addr[47:32] = 16'h0040;
        #1 chk("rw_rtr_rd", rtr, 3'b100);
        cyc();
        req_rts = 3'b010;  req_op[1] = 1'b1;  req_addr[31:16] = 16'h0040;
        req_data[63:32] = 32'h12345678;  req_wben[7:4] = 4'b0011;
        #1 chk("rw_rtr_wr", rtr, 3'b010);
        cyc();
        req_rts = '0;
        cyc();
        chk("rw_xfc_early", xfc, 3'b000);
        cyc();
        chk("rw_xfc", xfc, 3'b100);
        chk("rw_old_data", rsp_data, 32'hDEADBEEF);

        // Requester 0 reads back the byte-merged word.
        req_rts = 3'b001;  req_op = 3'b000;  req_addr[15:0] = 16'h0040;
        #1 chk("rb_rtr", rtr, 3'b001);
        cyc();
        req_rts = '0;
        cyc();
        cyc();
        chk("rb_xfc_early", xfc, 3'b000);
        cyc();
        chk("rb_xfc", xfc, 3'b001);
        chk("rb_data", rsp_data, 32'hDEAD5678);

        // Reset with a read in flight: its response must never appear.
        req_rts = 3'b010;  req_op = 3'b000;  req_addr[31:16] = 16'h0040;
        #1 chk("rf_rtr", rtr, 3'b010);
        cyc();
        req_rts = '0;  rst_ = 1'b1;
        chk("rf_inflight_en", mem_en, 1'b1);
        cyc();
        rst_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rf_no_xfc", xfc, 3'b000);
            cyc();
        end
        chk("rf_rsp_data", rsp_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
